// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
//
// Output buffer for one destination port of the 1x3 packet router. It stores
// the byte stream from the register/parity stage while write_enb is high.
// Each stored byte carries a header tag (lfd_state), so the read side can
// find packet boundaries. A remaining-byte counter is loaded from each header
// as the header is read out. pkt_active stays high until the parity byte of
// that packet has been read.
//
// Parameters:
//   DATA_W  payload byte width (stored word is DATA_W+1 bits wide)
//   DEPTH   number of entries, power of two
//   ADDR_W  log2(DEPTH); the pointers carry one extra wrap bit
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   soft_reset  synchronous active-high flush (controller timeout)
//   write_enb   write request
//   read_enb    read request
//   lfd_state   the current write byte is a header; stored as the tag bit
//   data_in     byte from the register stage
//   full        no free entry
//   empty       no stored entry
//   data_out    registered read data, held while idle
//   pkt_active  read-side packet in progress
//
// Optional feature (macro ROUTER_FIFO_ERR_FLAGS_EN):
//   overflow    sticky; set by a write attempt while full
//   underflow   sticky; set by a read attempt while empty
// ---------------------------------------------------------------------------
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data_out,
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              pkt_active
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W:0] mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [6:0]      rem_cnt;

    logic            clear;
    logic            wr_fire;
    logic            rd_fire;
    logic [DATA_W:0] rd_word;
    logic [6:0]      hdr_len;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A flush overrides any read or write presented on the same edge.
    assign clear   = !rst || soft_reset;
    assign wr_fire = write_enb && !full && !clear;
    assign rd_fire = read_enb && !empty && !clear;

    assign rd_word = mem[rd_ptr[ADDR_W-1:0]];
    // Header carries the payload length in bits [7:2]; +1 counts the parity byte.
    assign hdr_len = {1'b0, rd_word[7:2]} + 7'd1;

    assign pkt_active = (rem_cnt != 7'd0);

    // Storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rem_cnt  <= '0;
            data_out <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_word[DATA_W-1:0];
                // A header reloads the counter even when a packet is still open.
                if (rd_word[DATA_W]) begin
                    rem_cnt <= hdr_len;
                end else if (rem_cnt != 7'd0) begin
                    rem_cnt <= rem_cnt - 7'd1;
                end
            end
        end
    end

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enb && full) begin
                overflow <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_fifo
//
// Scoreboard bench for router_fifo. Each step presents one cycle of stimulus
// and advances a queue-based reference model. Every expected data_out update
// is pushed onto a scoreboard queue. A separate monitor pops that queue after
// each update edge. It also compares the flags with the model every cycle.
// ---------------------------------------------------------------------------
module tb_router_fifo;

    logic       clk;
    logic       rst;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;
    logic       pkt_active;
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    router_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out),
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
        .overflow   (overflow),
        .underflow  (underflow),
`endif
        .pkt_active (pkt_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the FIFO contents as a queue of {tag, byte}.
    logic [8:0] model_q [$];
    int         model_rem = 0;
    bit         model_ovf = 0;
    bit         model_unf = 0;

    // Scoreboard of expected data_out values, one entry per update edge.
    logic [7:0] exp_q [$];
    bit         upd_pending = 0;
    bit         exp_empty = 1;
    bit         exp_full = 0;
    bit         exp_pkt = 0;
    bit         mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents one cycle of stimulus and advances the model to the state
    // the DUT must hold after the next rising edge.
    task automatic step(input bit rstn, input bit srst, input bit we, input bit re,
                        input bit lfd, input logic [7:0] din);
        logic [8:0] w;
        bit was_full, was_empty;
        rst        = rstn;
        soft_reset = srst;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        upd_pending = 0;
        if (!rstn || srst) begin
            model_q.delete();
            model_rem = 0;
            model_ovf = 0;
            model_unf = 0;
            exp_q.push_back(8'h00);
            upd_pending = 1;
        end else begin
            was_full  = (model_q.size() == 16);
            was_empty = (model_q.size() == 0);
            if (we && was_full) model_ovf = 1;
            if (re && was_empty) model_unf = 1;
            if (re && !was_empty) begin
                w = model_q.pop_front();
                exp_q.push_back(w[7:0]);
                upd_pending = 1;
                if (w[8]) model_rem = int'(w[7:2]) + 1;
                else if (model_rem > 0) model_rem--;
            end
            if (we && !was_full) model_q.push_back({lfd, din});
        end
        exp_empty = (model_q.size() == 0);
        exp_full  = (model_q.size() == 16);
        exp_pkt   = (model_rem != 0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: pops one expectation per data_out update; checks flags every cycle.
    logic [7:0] last_dout = 8'h00;
    always @(posedge clk) begin
        bit upd;
        if (mon_en) begin
            upd = upd_pending;
            #1;
            if (upd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard_underrun: queue empty at %0t", $time);
                end else begin
                    last_dout = exp_q.pop_front();
                end
            end
            check("data_out", 32'(data_out), 32'(last_dout));
            check("empty", 32'(empty), 32'(exp_empty));
            check("full", 32'(full), 32'(exp_full));
            check("pkt_active", 32'(pkt_active), 32'(exp_pkt));
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
            check("overflow", 32'(overflow), 32'(model_ovf));
            check("underflow", 32'(underflow), 32'(model_unf));
`endif
        end
    end

    initial begin
        logic [7:0] pkt [5];
        pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h3F;

        // Reset, then idle.
        mon_en = 1;
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        idle(2);

        // Single packet round trip: header 0x0D carries length 3.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, (i == 0), pkt[i]);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 8'h00);
        idle(2);

        // Fill to full, then an overflowing write of 0xAA.
        for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 0, 8'(i));
        step(1, 0, 1, 0, 0, 8'hAA);
        idle(1);
        // Read and write together while full: the read wins and 0x55 is dropped.
        step(1, 0, 1, 1, 0, 8'h55);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 0, 8'h00);
        // A read on empty is ignored.
        step(1, 0, 0, 1, 0, 8'h00);
        idle(2);

        // Pointer wrap: interleaved single write/read pairs.
        step(1, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 1, 0, 0, 8'(i));
            step(1, 0, 0, 1, 0, 8'h00);
        end
        idle(1);

        // soft_reset during a 5-byte packet (header 0x14), after three reads.
        step(1, 0, 1, 0, 1, 8'h14);
        for (int i = 1; i < 7; i++) step(1, 0, 1, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 8'h00);
        step(1, 1, 0, 1, 0, 8'h00);
        idle(2);

        // Random traffic with occasional headers, flushes and resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) != 0), ($urandom_range(49) == 0),
                 ($urandom_range(99) < 55), ($urandom_range(99) < 45),
                 ($urandom_range(7) == 0), 8'($urandom));
        end
        idle(3);

        mon_en = 0;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
